// File: rtl/pinball_pkg.sv
// rtl/pinball_pkg.sv - shared game-state encodings and table sizes for the pinball controller and score datapath
package pinball_pkg;

    localparam int NUM_HOLES  = 8;
    localparam int NUM_GROUPS = 8;
    localparam int GROUP_W    = $clog2(NUM_GROUPS);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_GET   = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    // Counter width that holds the largest of three intervals without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pinball_ctrl_cycle_timer.sv
// rtl/pinball_ctrl_cycle_timer.sv - interval counter with clear, enable and terminal-count flag
module cycle_timer #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] count;

    // done marks the PERIOD-th enabled cycle; the counter restarts from zero after it.
    assign done = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pinball_ctrl.sv
// rtl/pinball_ctrl.sv - pinball game sequencer: group rotation, ball launch, hole capture, game over
module pinball_ctrl
    import pinball_pkg::*;
#(
    parameter int NUM_BALLS    = 3,
    parameter int GROUP_PERIOD = 25_000_000,
    parameter int BALL_TIMEOUT = 500_000_000,
    parameter int HOLD_CYCLES  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch,
    input  logic                 restart,
    input  logic [NUM_HOLES-1:0] ball,
    input  logic                 win,
    output logic [2:0]           state,
    output logic [GROUP_W-1:0]   selected_group,
    output logic [1:0]           balls_left,
    output logic [NUM_HOLES-1:0] hole
);

    localparam int CNT_W = cnt_width(GROUP_PERIOD, BALL_TIMEOUT, HOLD_CYCLES);
    localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);

    game_state_t st;
    logic        group_tick;
    logic        ball_timeout;
    logic        hold_done;
    logic        ball_seen;

    assign state     = st;
    assign ball_seen = (ball != '0);

    // Each timer is held cleared outside its own state, so it starts from zero on entry.
    cycle_timer #(.WIDTH(CNT_W), .PERIOD(GROUP_PERIOD)) u_group_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (st != ST_WAIT),
        .enable (st == ST_WAIT),
        .done   (group_tick)
    );

    cycle_timer #(.WIDTH(CNT_W), .PERIOD(BALL_TIMEOUT)) u_ball_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (st != ST_START),
        .enable ((st == ST_START) && !ball_seen),
        .done   (ball_timeout)
    );

    cycle_timer #(.WIDTH(CNT_W), .PERIOD(HOLD_CYCLES)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (st != ST_GET),
        .enable (st == ST_GET),
        .done   (hold_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= ST_RESET;
            selected_group <= '0;
            balls_left     <= BALLS_INIT;
            hole           <= '0;
        end else if (restart) begin
            st <= ST_RESET;
        end else begin
            case (st)
                ST_RESET: begin
                    st             <= ST_WAIT;
                    selected_group <= '0;
                    balls_left     <= BALLS_INIT;
                    hole           <= '0;
                end
                ST_WAIT: begin
                    // The group seen in the launch cycle is the one the ball plays for.
                    if (launch) begin
                        st <= ST_START;
                    end else if (group_tick) begin
                        selected_group <= selected_group + 1'b1;
                    end
                end
                ST_START: begin
                    if (ball_seen || ball_timeout) begin
                        hole       <= ball_seen ? ball : '0;
                        balls_left <= (balls_left == 2'd0) ? 2'd0 : balls_left - 2'd1;
                        st         <= ST_GET;
                    end
                end
                ST_GET: begin
                    if (hold_done) begin
                        st <= (win || balls_left == 2'd0) ? ST_OVER : ST_WAIT;
                    end
                end
                ST_OVER: begin
                    st <= ST_OVER;
                end
                default: begin
                    st <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pinball_ctrl.sv
// tb/tb_pinball_ctrl.sv - self-checking bench for pinball_ctrl against a cycle-count reference model
module tb_pinball_ctrl;

    localparam int GP = 4;
    localparam int BT = 16;
    localparam int HC = 3;
    localparam int NB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       launch = 1'b0;
    logic       restart = 1'b0;
    logic       win = 1'b0;
    logic [7:0] ball = 8'h00;
    logic [2:0] state;
    logic [2:0] selected_group;
    logic [1:0] balls_left;
    logic [7:0] hole;

    int checks = 0;
    int failures = 0;

    // Reference model: state code, group, balls, hole, and cycles spent in the current state.
    int m_state = 0;
    int m_group = 0;
    int m_balls = NB;
    int m_hole  = 0;
    int m_el    = 0;

    pinball_ctrl #(
        .NUM_BALLS    (NB),
        .GROUP_PERIOD (GP),
        .BALL_TIMEOUT (BT),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .launch         (launch),
        .restart        (restart),
        .ball           (ball),
        .win            (win),
        .state          (state),
        .selected_group (selected_group),
        .balls_left     (balls_left),
        .hole           (hole)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_group = 0;
        m_balls = NB;
        m_hole  = 0;
        m_el    = 0;
    endtask

    task automatic model_step();
        int nxt;
        nxt = m_state;
        if (restart) begin
            nxt = 0;
        end else begin
            case (m_state)
                0: begin
                    nxt = 1; m_group = 0; m_balls = NB; m_hole = 0;
                end
                1: begin
                    if (launch) nxt = 2;
                    else if ((m_el + 1) % GP == 0) m_group = (m_group + 1) % 8;
                end
                2: begin
                    if (ball != 8'h00 || m_el + 1 == BT) begin
                        m_hole  = int'(ball);
                        m_balls = (m_balls > 0) ? m_balls - 1 : 0;
                        nxt     = 3;
                    end
                end
                3: begin
                    if (m_el + 1 == HC) nxt = (win || m_balls == 0) ? 4 : 1;
                end
                4: nxt = 4;
                default: nxt = 0;
            endcase
        end
        m_el    = (nxt == m_state) ? m_el + 1 : 0;
        m_state = nxt;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_state", int'(state), m_state);
            chk("model_group", int'(selected_group), m_group);
            chk("model_balls", int'(balls_left), m_balls);
            chk("model_hole",  int'(hole), m_hole);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        tick(1);
        chk("rst_state", int'(state), 0);
        chk("rst_group", int'(selected_group), 0);
        chk("rst_balls", int'(balls_left), 3);
        chk("rst_hole",  int'(hole), 0);
        rst = 1'b0;
        tick(1);
        chk("wait_entry", int'(state), 1);
        tick(4);  chk("group_1", int'(selected_group), 1);
        tick(4);  chk("group_2", int'(selected_group), 2);
        tick(20); chk("group_7", int'(selected_group), 7);
        tick(4);  chk("group_wrap", int'(selected_group), 0);
        tick(12); chk("group_3", int'(selected_group), 3);

        launch = 1'b1; tick(1); launch = 1'b0;
        chk("start_state", int'(state), 2);
        chk("start_group", int'(selected_group), 3);
        ball = 8'h08; tick(1);
        chk("get_state", int'(state), 3);
        chk("get_hole", int'(hole), 8);
        chk("get_balls", int'(balls_left), 2);
        tick(2); chk("get_hold", int'(state), 3);
        tick(1); chk("back_wait", int'(state), 1);
        chk("group_kept", int'(selected_group), 3);
        ball = 8'h00;

        launch = 1'b1; tick(1); launch = 1'b0;
        tick(15); chk("timeout_start", int'(state), 2);
        tick(1);
        chk("timeout_get", int'(state), 3);
        chk("timeout_hole", int'(hole), 0);
        chk("timeout_balls", int'(balls_left), 1);
        tick(3);
        launch = 1'b1; tick(1); launch = 1'b0;
        ball = 8'h81; tick(1);
        chk("multibit_hole", int'(hole), 8'h81);
        chk("last_ball", int'(balls_left), 0);
        ball = 8'h00;
        tick(3);
        chk("over_state", int'(state), 4);
        chk("over_balls", int'(balls_left), 0);

        launch = 1'b1; tick(1); launch = 1'b0;
        chk("over_launch", int'(state), 4);
        restart = 1'b1; tick(1); restart = 1'b0;
        chk("restart_reset", int'(state), 0);
        tick(1);
        chk("restart_wait", int'(state), 1);
        chk("restart_balls", int'(balls_left), 3);
        launch = 1'b1; tick(1); launch = 1'b0;
        ball = 8'h01; tick(1); ball = 8'h00;
        win = 1'b1;
        tick(2); chk("win_hold", int'(state), 3);
        tick(1);
        chk("win_over", int'(state), 4);
        chk("win_balls", int'(balls_left), 2);
        win = 1'b0;

        restart = 1'b1; tick(1); restart = 1'b0;
        tick(1);
        launch = 1'b1; restart = 1'b1; tick(1); launch = 1'b0; restart = 1'b0;
        chk("launch_restart", int'(state), 0);
        tick(1);
        launch = 1'b1; tick(1); launch = 1'b0;
        ball = 8'h04; tick(1); ball = 8'h00;
        tick(3);
        chk("hole_kept_wait", int'(hole), 4);
        launch = 1'b1; tick(1); launch = 1'b0;
        ball = 8'h20; restart = 1'b1; tick(1); ball = 8'h00; restart = 1'b0;
        chk("ball_restart", int'(state), 0);
        chk("ball_restart_hole", int'(hole), 4);
        tick(1);
        chk("hole_cleared", int'(hole), 0);

        tick(4);
        launch = 1'b1; tick(1); launch = 1'b0;
        ball = 8'h02; tick(1); ball = 8'h00;
        tick(3);
        launch = 1'b1; tick(1); launch = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_group", int'(selected_group), 0);
        chk("async_balls", int'(balls_left), 3);
        chk("async_hole",  int'(hole), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("async_wait", int'(state), 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            launch  = ($urandom_range(3) == 0);
            restart = ($urandom_range(63) == 0);
            ball    = ($urandom_range(5) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            win     = ($urandom_range(3) == 0);
            rst     = ($urandom_range(199) == 0);
        end
        @(negedge clk);
        launch = 1'b0; restart = 1'b0; ball = 8'h00; win = 1'b0; rst = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
